// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings and pointer wrap helper.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Increment a channel index, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping from N-1 to 0. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    int off;
    int best_off;

    // Choose the requester with the smallest circular distance from ptr.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        off         = 0;
        best_off    = N;
        for (int i = 0; i < N; i++) begin
            off = (i - int'(ptr) + N) % N;
            if (req[i] && (off < best_off)) begin
                best_off    = off;
                grant       = SEL_W'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-channel registered stream multiplexer with valid/ready handshakes.
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both high; valid never waits for ready, and ready here is a pure
// function of the grant and the output register's ability to load.
module stream_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_ch,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic [SEL_W-1:0] rr_grant;
    logic             rr_grant_valid;
    logic             sel_grant_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic             can_load;
    logic             accept;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant       (rr_grant),
        .grant_valid (rr_grant_valid)
    );

    // Select-mode grant: sel must name an existing channel that is valid.
    always_comb begin
        sel_grant_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((sel == SEL_W'(i)) && in_valid[i]) begin
                sel_grant_valid = 1'b1;
            end
        end
    end

    // Mode mux, ready generation and data slice for the granted channel.
    always_comb begin
        grant       = (mode == MODE_RR) ? rr_grant : sel;
        grant_valid = (mode == MODE_RR) ? rr_grant_valid : sel_grant_valid;
        can_load    = !out_valid_q || out_ready;
        accept      = grant_valid && can_load;
        in_ready    = '0;
        grant_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SEL_W'(i)) begin
                in_ready[i] = accept;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant;
            if (mode == MODE_RR) begin
                ptr_d = SEL_W'(wrap_inc(int'(grant), N));
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held beat and rewinds the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a 4-channel instance for the main scenarios
// and a 3-channel instance for the non-power-of-two cases.
module tb_stream_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic         mode4;
    logic [1:0]   sel4;
    logic [3:0]   in_valid4;
    logic [127:0] in_data4;
    logic [3:0]   in_ready4;
    logic         out_valid4;
    logic [31:0]  out_data4;
    logic [1:0]   out_ch4;
    logic         out_ready4;

    // 3-channel instance
    logic         mode3;
    logic [1:0]   sel3;
    logic [2:0]   in_valid3;
    logic [95:0]  in_data3;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [31:0]  out_data3;
    logic [1:0]   out_ch3;
    logic         out_ready3;

    stream_mux #(.WIDTH(32), .N(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode4), .sel(sel4),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
        .out_ready(out_ready4)
    );

    stream_mux #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboards: {channel, data} expected on the output register.
    logic [33:0] exp_q[$];
    logic [33:0] exp3_q[$];
    logic [33:0] last4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = $urandom();
        for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = $urandom();
    endtask

    // Expect channel g of the 4-channel instance to be granted now.
    task automatic expect_grant4(input int g);
        logic [3:0] onehot;
        onehot = 4'b0001 << g;
        chk("in_ready4", 64'(in_ready4), 64'(onehot));
        exp_q.push_back({2'(g), in_data4[g*32 +: 32]});
    endtask

    task automatic expect_grant3(input int g);
        logic [2:0] onehot;
        onehot = 3'b001 << g;
        chk("in_ready3", 64'(in_ready3), 64'(onehot));
        exp3_q.push_back({2'(g), in_data3[g*32 +: 32]});
    endtask

    task automatic check_out4();
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb4_empty observed=%0h expected=none", {out_ch4, out_data4});
        end else begin
            e = exp_q.pop_front();
            last4 = e;
            chk("out_valid4", 64'(out_valid4), 64'd1);
            chk("out_ch4", 64'(out_ch4), 64'(e[33:32]));
            chk("out_data4", 64'(out_data4), 64'(e[31:0]));
        end
    endtask

    task automatic check_out3();
        logic [33:0] e;
        if (exp3_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb3_empty observed=%0h expected=none", {out_ch3, out_data3});
        end else begin
            e = exp3_q.pop_front();
            chk("out_valid3", 64'(out_valid3), 64'd1);
            chk("out_ch3", 64'(out_ch3), 64'(e[33:32]));
            chk("out_data3", 64'(out_data3), 64'(e[31:0]));
        end
    endtask

    initial begin
        int rr_seq[5];
        int skip_seq[3];
        int rr3_seq[4];
        rr_seq   = '{0, 1, 2, 3, 0};
        skip_seq = '{3, 0, 3};
        rr3_seq  = '{0, 1, 2, 0};

        rst = 1'b1;
        mode4 = 1'b0; sel4 = 2'd0; in_valid4 = '0; in_data4 = '0; out_ready4 = 1'b0;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b0;
        step();
        step();

        // Reset state of both instances.
        chk("rst_out_valid4", 64'(out_valid4), 64'd0);
        chk("rst_out_data4", 64'(out_data4), 64'd0);
        chk("rst_out_ch4", 64'(out_ch4), 64'd0);
        chk("rst_in_ready4", 64'(in_ready4), 64'd0);
        chk("rst_out_valid3", 64'(out_valid3), 64'd0);
        rst = 1'b0;

        // Select mode: sel=2 with all channels valid.
        step();
        randomize_data();
        in_data4[64 +: 32] = 32'hA5A5A5A5;
        mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b1111; out_ready4 = 1'b1;
        settle();
        expect_grant4(2);
        step();
        check_out4();

        // Select mode: sel=3 while channel 3 idle -> no accept, output drains.
        sel4 = 2'd3; in_valid4 = 4'b0111;
        settle();
        chk("sel_idle_in_ready4", 64'(in_ready4), 64'd0);
        step();
        chk("sel_idle_out_valid4", 64'(out_valid4), 64'd0);

        // Round-robin, all valid: 0,1,2,3,0 back to back.
        mode4 = 1'b1; in_valid4 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            randomize_data();
            settle();
            expect_grant4(rr_seq[k]);
            step();
            check_out4();
        end

        // Round-robin skip with pointer at 1: 3,0,3.
        in_valid4 = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            randomize_data();
            settle();
            expect_grant4(skip_seq[k]);
            step();
            check_out4();
        end

        // Back-pressure for three cycles; mode/sel wiggle must not disturb the beat.
        out_ready4 = 1'b0; in_valid4 = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            randomize_data();
            mode4 = k[0];
            sel4 = 2'(k);
            settle();
            chk("stall_in_ready4", 64'(in_ready4), 64'd0);
            step();
            chk("stall_out_valid4", 64'(out_valid4), 64'd1);
            chk("stall_out_ch4", 64'(out_ch4), 64'(last4[33:32]));
            chk("stall_out_data4", 64'(out_data4), 64'(last4[31:0]));
        end

        // Release: drain and reload on the same edge (pointer is 0 after 3,0,3).
        mode4 = 1'b1; out_ready4 = 1'b1;
        randomize_data();
        settle();
        expect_grant4(0);
        step();
        check_out4();

        // Asynchronous reset with a held beat; pointer (now 1) must return to 0.
        out_ready4 = 1'b0;
        rst = 1'b1;
        settle();
        chk("async_rst_out_valid4", 64'(out_valid4), 64'd0);
        chk("async_rst_out_data4", 64'(out_data4), 64'd0);
        chk("async_rst_out_ch4", 64'(out_ch4), 64'd0);
        step();
        rst = 1'b0;
        out_ready4 = 1'b1; mode4 = 1'b1; in_valid4 = 4'b1111;
        randomize_data();
        settle();
        expect_grant4(0);
        step();
        check_out4();
        in_valid4 = '0;
        step();

        // N=3: sel=3 names no channel.
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        randomize_data();
        settle();
        chk("n3_sel3_in_ready3", 64'(in_ready3), 64'd0);
        step();
        chk("n3_sel3_out_valid3", 64'(out_valid3), 64'd0);

        // N=3 round-robin: pointer wraps 2 -> 0.
        mode3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            randomize_data();
            settle();
            expect_grant3(rr3_seq[k]);
            step();
            check_out3();
        end
        in_valid3 = '0;
        step();

        chk("sb4_leftover", 64'(exp_q.size()), 64'd0);
        chk("sb3_leftover", 64'(exp3_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
